// File: rtl/ts_reader_if.sv
// Shared SPI bus plus the arbiter req/gnt handshake, as seen by the touchscreen reader.
interface ts_reader_if;
    logic bus_req;
    logic bus_gnt;
    logic sclk;
    logic mosi;
    logic miso;
    logic csn;

    modport master (output bus_req, sclk, mosi, csn, input bus_gnt, miso);
    modport slave  (input bus_req, sclk, mosi, csn, output bus_gnt, miso);
endinterface

// File: rtl/ts_reader.sv
// XPT2046/TSC2046 touchscreen reader: arbitrates for the shared SPI bus, runs Z1/X/Y
// 12-bit differential conversions and latches the coordinates.
module ts_reader #(
    parameter int unsigned CLK_DIV   = 8,
    parameter logic [11:0] PRESS_MIN = 12'd100
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    ts_reader_if.master        bus,
    output logic               busy,
    output logic               valid,
    output logic               touched,
    output logic [11:0]        x,
    output logic [11:0]        y,
    output logic [11:0]        z1
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {IDLE, REQ, LEAD, SHIFT, TRAIL, DONE} state_t;

    state_t           state;
    logic [DIV_W-1:0] div;
    logic [4:0]       bit_cnt;
    logic [1:0]       ch;
    logic [11:0]      shreg;
    logic [11:0]      z1_raw;
    logic [11:0]      x_raw;
    logic [11:0]      y_raw;
    logic             div_last;

    assign div_last = (div == DIV_W'(CLK_DIV - 1));

    // Command bit for SCLK period b of channel c; shifting past bit 7 yields the zero tail.
    function automatic logic mosi_bit(input logic [1:0] c, input logic [4:0] b);
        logic [7:0] cmd;
        case (c)
            2'd0:    cmd = 8'hB0;
            2'd1:    cmd = 8'hD0;
            default: cmd = 8'h90;
        endcase
        cmd = cmd << b;
        return cmd[7];
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: results and partial samples are cleared too, so a reset mid-transfer never leaks stale data.
            state       <= IDLE;
            div         <= '0;
            bit_cnt     <= '0;
            ch          <= '0;
            shreg       <= '0;
            z1_raw      <= '0;
            x_raw       <= '0;
            y_raw       <= '0;
            bus.bus_req <= 1'b0;
            bus.sclk    <= 1'b0;
            bus.mosi    <= 1'b0;
            bus.csn     <= 1'b1;
            busy        <= 1'b0;
            valid       <= 1'b0;
            touched     <= 1'b0;
            x           <= '0;
            y           <= '0;
            z1          <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= REQ;
                        busy        <= 1'b1;
                        bus.bus_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus.bus_gnt) begin
                        state   <= LEAD;
                        bus.csn <= 1'b0;
                        div     <= '0;
                    end
                end
                LEAD: begin
                    if (div_last) begin
                        div      <= '0;
                        state    <= SHIFT;
                        ch       <= 2'd0;
                        bit_cnt  <= 5'd0;
                        bus.mosi <= mosi_bit(2'd0, 5'd0);
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                SHIFT: begin
                    if (!div_last) begin
                        div <= div + 1'b1;
                    end else begin
                        div <= '0;
                        if (!bus.sclk) begin
                            // Rising edge: the controller's data bit is stable, capture it.
                            bus.sclk <= 1'b1;
                            if (bit_cnt >= 5'd9 && bit_cnt <= 5'd20)
                                shreg <= {shreg[10:0], bus.miso};
                        end else begin
                            bus.sclk <= 1'b0;
                            if (bit_cnt != 5'd23) begin
                                bit_cnt  <= bit_cnt + 5'd1;
                                bus.mosi <= mosi_bit(ch, bit_cnt + 5'd1);
                            end else begin
                                bit_cnt <= 5'd0;
                                case (ch)
                                    2'd0:    z1_raw <= shreg;
                                    2'd1:    x_raw  <= shreg;
                                    default: y_raw  <= shreg;
                                endcase
                                if (ch == 2'd2) begin
                                    ch       <= 2'd0;
                                    bus.mosi <= 1'b0;
                                    state    <= TRAIL;
                                end else begin
                                    ch       <= ch + 2'd1;
                                    bus.mosi <= mosi_bit(ch + 2'd1, 5'd0);
                                end
                            end
                        end
                    end
                end
                TRAIL: begin
                    if (div_last) begin
                        div         <= '0;
                        bus.csn     <= 1'b1;
                        bus.bus_req <= 1'b0;
                        busy        <= 1'b0;
                        valid       <= 1'b1;
                        state       <= DONE;
                        z1          <= z1_raw;
                        // A light press gives unreliable coordinates, so keep the last good ones.
                        if (z1_raw >= PRESS_MIN) begin
                            x       <= x_raw;
                            y       <= y_raw;
                            touched <= 1'b1;
                        end else begin
                            touched <= 1'b0;
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
